// File: rtl/seg_hc595_scan_n.sv
// seg_hc595_scan_n: binary word -> multiplexed common-anode 7-seg display driven
// through a 74HC595 chain. Sequential double-dabble conversion, leading-zero
// blanking, sign placement, overflow detection, digit scan and serial shifting.
// Optional feature macro: BRIGHTNESS_PWM_EN (adds bright[3:0], PWM on oe).
//
// Shifter FSM
//   state    | meaning
//   SH_IDLE  | chain idle, ds/shcp/stcp low
//   SH_SHIFT | serialising frame word, 4 clocks per bit
//   SH_LATCH | stcp high for 4 clocks
// Conversion FSM
//   state    | meaning
//   CV_IDLE  | waiting for next pass wrap
//   CV_SHIFT | double-dabble iterations, one input bit per clock
//   CV_FIN   | build segment image from BCD result into pending image
module seg_hc595_scan_n #(
    parameter int DIGITS   = 6,
    parameter int DATA_W   = 20,
    parameter int CLK_FREQ = 50_000_000,
    parameter int SCAN_US  = 1000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic [DIGITS-1:0] point,
    input  logic              sign,
    input  logic              seg_en,
`ifdef BRIGHTNESS_PWM_EN
    input  logic [3:0]        bright,
`endif
    output logic              ds,
    output logic              shcp,
    output logic              stcp,
    output logic              oe,
    output logic              ovf
);

    localparam int SCAN_CYC  = CLK_FREQ / 1_000_000 * SCAN_US;
    localparam int CH_W      = 8 + DIGITS;
    localparam int FRAME_LEN = 4 * CH_W + 4;
    localparam int CW        = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam int IW        = $clog2(DIGITS);
    localparam int HW        = $clog2(DIGITS + 1);
    localparam int NB        = 9;   // enough BCD digits for any 27-bit input
    localparam int BW        = $clog2(DATA_W + 1);
    localparam int KW        = $clog2(CH_W);

    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    if (SCAN_CYC < FRAME_LEN + 2) begin : g_cfg_err
        $error("seg_hc595_scan_n: SCAN_CYC shorter than one 595 frame plus 2");
    end

    typedef enum logic [1:0] {SH_IDLE, SH_SHIFT, SH_LATCH} sh_state_t;
    typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_FIN} cv_state_t;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    // scan timing
    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] idx;
    logic          wrap, pass_wrap, load;

    // conversion
    cv_state_t              cv_state, cv_nxt;
    logic [DATA_W-1:0]      bin, bin_nxt;
    logic [4*NB-1:0]        bcd, bcd_nxt, bcd_adj;
    logic [BW-1:0]          bits, bits_nxt;
    logic [DIGITS-1:0]      pt_s, pt_nxt;
    logic                   sign_s, sign_nxt, en_s, en_nxt;
    logic [DIGITS-1:0][7:0] seg_calc, pend_seg, pend_seg_nxt, disp_seg;
    logic                   pend_en, pend_en_nxt, pend_ovf, pend_ovf_nxt, disp_en;
    logic [HW-1:0]          hi;
    logic                   big, ovf_calc;

    // shifter
    sh_state_t         sh_state, sh_nxt;
    logic [CH_W-1:0]   sreg, sreg_nxt, w_frame;
    logic [DIGITS-1:0] sel;
    logic [1:0]        phase, phase_nxt;
    logic [KW-1:0]     bcnt, bcnt_nxt;
    logic              ds_nxt, shcp_nxt, stcp_nxt, armed, armed_nxt;

    assign wrap      = (cnt == CW'(SCAN_CYC - 1));
    assign pass_wrap = wrap && (idx == IW'(DIGITS - 1));
    assign load      = (cnt == '0);

    // next dwell count
    always_comb begin
        cnt_nxt = wrap ? '0 : cnt + CW'(1);
    end

    // dwell counter and digit index
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (wrap)
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end
    end

    // blanking, sign placement and overflow from the finished BCD value
    always_comb begin
        hi       = '0;
        seg_calc = '1;
        big      = |bcd[4*NB-1:4*DIGITS];
        for (int i = 0; i < DIGITS; i++)
            if (bcd[4*i +: 4] != 4'd0 || pt_s[i])
                hi = HW'(i);
        ovf_calc = big | (sign_s & (hi == HW'(DIGITS - 1)));
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_calc)
                seg_calc[i] = SEG_DASH;
            else if (HW'(i) <= hi)
                seg_calc[i] = seg_code(bcd[4*i +: 4]) & {~pt_s[i], 7'h7F};
            else if (sign_s && HW'(i) == hi + HW'(1))
                seg_calc[i] = SEG_DASH;
            else
                seg_calc[i] = SEG_BLANK;
        end
    end

    // conversion FSM next state and datapath
    always_comb begin
        cv_nxt       = cv_state;
        bin_nxt      = bin;
        bcd_nxt      = bcd;
        bits_nxt     = bits;
        pt_nxt       = pt_s;
        sign_nxt     = sign_s;
        en_nxt       = en_s;
        pend_seg_nxt = pend_seg;
        pend_en_nxt  = pend_en;
        pend_ovf_nxt = pend_ovf;
        bcd_adj      = bcd;
        for (int k = 0; k < NB; k++)
            if (bcd[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        if (pass_wrap) begin
            cv_nxt   = CV_SHIFT;
            bin_nxt  = data;
            bcd_nxt  = '0;
            bits_nxt = BW'(DATA_W);
            pt_nxt   = point;
            sign_nxt = sign;
            en_nxt   = seg_en;
        end else begin
            case (cv_state)
                CV_SHIFT: begin
                    {bcd_nxt, bin_nxt} = {bcd_adj, bin} << 1;
                    bits_nxt = bits - BW'(1);
                    if (bits == BW'(1))
                        cv_nxt = CV_FIN;
                end
                CV_FIN: begin
                    pend_seg_nxt = seg_calc;
                    pend_en_nxt  = en_s;
                    pend_ovf_nxt = ovf_calc;
                    cv_nxt       = CV_IDLE;
                end
                default: cv_nxt = CV_IDLE;
            endcase
        end
    end

    // conversion FSM registers
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cv_state <= CV_IDLE;
            bin      <= '0;
            bcd      <= '0;
            bits     <= '0;
            pt_s     <= '0;
            sign_s   <= 1'b0;
            en_s     <= 1'b1;
            pend_seg <= '1;
            pend_en  <= 1'b1;
            pend_ovf <= 1'b0;
        end else begin
            cv_state <= cv_nxt;
            bin      <= bin_nxt;
            bcd      <= bcd_nxt;
            bits     <= bits_nxt;
            pt_s     <= pt_nxt;
            sign_s   <= sign_nxt;
            en_s     <= en_nxt;
            pend_seg <= pend_seg_nxt;
            pend_en  <= pend_en_nxt;
            pend_ovf <= pend_ovf_nxt;
        end
    end

    // displayed image swaps only at pass boundaries so a pass never tears
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            disp_seg <= '1;
            disp_en  <= 1'b1;
            ovf      <= 1'b0;
        end else if (pass_wrap) begin
            disp_seg <= pend_seg;
            disp_en  <= pend_en;
            ovf      <= pend_ovf;
        end
    end

    // frame word for the current digit
    always_comb begin
        sel     = DIGITS'(1) << idx;
        w_frame = disp_en ? {disp_seg[idx], sel} : {SEG_BLANK, {DIGITS{1'b0}}};
    end

    // shifter FSM next state and pin values
    always_comb begin
        sh_nxt    = sh_state;
        sreg_nxt  = sreg;
        phase_nxt = phase;
        bcnt_nxt  = bcnt;
        ds_nxt    = ds;
        shcp_nxt  = shcp;
        stcp_nxt  = stcp;
        armed_nxt = armed;
        if (load) begin
            sh_nxt    = SH_SHIFT;
            sreg_nxt  = w_frame;
            ds_nxt    = w_frame[0];
            shcp_nxt  = 1'b0;
            stcp_nxt  = 1'b0;
            phase_nxt = 2'd0;
            bcnt_nxt  = KW'(CH_W - 1);
        end else begin
            case (sh_state)
                SH_SHIFT: begin
                    phase_nxt = phase + 2'd1;
                    if (phase == 2'd1)
                        shcp_nxt = 1'b1;
                    if (phase == 2'd3) begin
                        shcp_nxt = 1'b0;
                        if (bcnt == '0) begin
                            sh_nxt   = SH_LATCH;
                            ds_nxt   = 1'b0;
                            stcp_nxt = 1'b1;
                        end else begin
                            sreg_nxt = sreg >> 1;
                            ds_nxt   = sreg[1];
                            bcnt_nxt = bcnt - KW'(1);
                        end
                    end
                end
                SH_LATCH: begin
                    phase_nxt = phase + 2'd1;
                    if (phase == 2'd3) begin
                        stcp_nxt  = 1'b0;
                        sh_nxt    = SH_IDLE;
                        armed_nxt = 1'b1;
                    end
                end
                default: begin
                    ds_nxt   = 1'b0;
                    shcp_nxt = 1'b0;
                    stcp_nxt = 1'b0;
                end
            endcase
        end
    end

    // shifter FSM registers
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sh_state <= SH_IDLE;
            sreg     <= '0;
            phase    <= '0;
            bcnt     <= '0;
            ds       <= 1'b0;
            shcp     <= 1'b0;
            stcp     <= 1'b0;
            armed    <= 1'b0;
        end else begin
            sh_state <= sh_nxt;
            sreg     <= sreg_nxt;
            phase    <= phase_nxt;
            bcnt     <= bcnt_nxt;
            ds       <= ds_nxt;
            shcp     <= shcp_nxt;
            stcp     <= stcp_nxt;
            armed    <= armed_nxt;
        end
    end

`ifdef BRIGHTNESS_PWM_EN
    logic [CW-1:0] thr, thr_nxt;

    // on-time threshold, refreshed at every dwell wrap
    always_comb begin
        thr_nxt = wrap ? CW'((40'(bright) * 40'(SCAN_CYC)) >> 4) : thr;
    end

    // oe low for the first thr cycles of each dwell once the chain is valid
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            thr <= '0;
            oe  <= 1'b1;
        end else begin
            thr <= thr_nxt;
            oe  <= ~(armed_nxt & (cnt_nxt < thr_nxt));
        end
    end
`else
    // outputs enabled permanently once the first frame has been latched
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)
            oe <= 1'b1;
        else
            oe <= ~armed_nxt;
    end
`endif

endmodule
